// File: rtl/unary_op_sched.sv
// -----------------------------------------------------------------------------
// unary_op_sched
//   Round-robin scheduler feeding a single unary-operator datapath.
//   NREQ = 2**IDW requesters compete for one execution slot. In IDLE the
//   winner (the first valid requester at or after the rotating pointer) is
//   accepted. The result is computed in EXEC and presented in RESP until the
//   consumer takes it.
//
//   Op codes: 0 ~x, 1 +x, 2 -x, 3 !x, 4 &x, 5 ~&x, 6 |x, 7 ~|x, 8 ^x, 9 ~^x.
//   Codes 10-15 return zero.
//
//   Optional build macro: UNARY_OP_SCHED_ERR_EN adds rsp_err, which flags
//   illegal op codes.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]       per-requester operation present
//   req_ready  [NREQ]       one-hot accept, only driven in IDLE
//   req_op     [4*NREQ]     per-requester op code
//   req_data   [SIZE*NREQ]  per-requester operand
//   rsp_valid  response available (RESP state)
//   rsp_ready  consumer accepts response
//   rsp_id     [IDW]        owning requester index
//   rsp_data   [SIZE]       result (1-bit results zero-extended)
//   rsp_err    illegal op flag (only with UNARY_OP_SCHED_ERR_EN)
//   busy       state is not IDLE
// -----------------------------------------------------------------------------
module unary_op_sched #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned IDW  = 2,
  localparam int unsigned NREQ = 2 ** IDW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [4*NREQ-1:0]      req_op,
  input  logic [SIZE*NREQ-1:0]   req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [SIZE-1:0]        rsp_data,
`ifdef UNARY_OP_SCHED_ERR_EN
  output logic                   rsp_err,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [3:0]      op_q;
  logic [SIZE-1:0] data_q;
  logic [IDW-1:0]  id_q;

  logic [IDW-1:0]  grant_id;
  logic            grant_found;
  logic [IDW-1:0]  cand;

  logic [SIZE-1:0] res;
  logic            res_illegal;

  // Rotating priority search: offset 0 is the pointer itself, and the
  // IDW-bit addition wraps naturally from NREQ-1 back to 0.
  always_comb begin
    grant_id    = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + IDW'(i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // rst_n gates the grant so req_ready reads zero throughout reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready = NREQ'(1) << grant_id;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    res         = '0;
    res_illegal = 1'b0;
    case (op_q)
      4'd0:    res    = ~data_q;
      4'd1:    res    = data_q;
      4'd2:    res    = '0 - data_q;
      4'd3:    res[0] = (data_q == '0);
      4'd4:    res[0] = &data_q;
      4'd5:    res[0] = ~&data_q;
      4'd6:    res[0] = |data_q;
      4'd7:    res[0] = ~|data_q;
      4'd8:    res[0] = ^data_q;
      4'd9:    res[0] = ~^data_q;
      default: res_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_q      <= '0;
      data_q    <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifdef UNARY_OP_SCHED_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_q   <= req_op[4*grant_id +: 4];
            data_q <= req_data[SIZE*grant_id +: SIZE];
            id_q   <= grant_id;
            ptr    <= grant_id + IDW'(1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= res;
          rsp_id    <= id_q;
`ifdef UNARY_OP_SCHED_ERR_EN
          rsp_err   <= res_illegal;
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifndef UNARY_OP_SCHED_ERR_EN
  // The illegal flag has no consumer unless the error port is built.
  logic unused_illegal;
  assign unused_illegal = res_illegal;
`endif

endmodule

// File: tb/tb_unary_op_sched.sv
module tb_unary_op_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_op;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
`ifdef UNARY_OP_SCHED_ERR_EN
  logic        rsp_err;
`endif

  unary_op_sched #(.SIZE(8), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef UNARY_OP_SCHED_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_rsp: got id %0d data %0h expected no response", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
`ifdef UNARY_OP_SCHED_ERR_EN
        check("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
      end
    end
  end

  // Called at posedge+1 with the DUT in IDLE. bp = cycles of held-off rsp_ready.
  task automatic issue(input logic [3:0] vm, input logic [3:0] op, input logic [7:0] d,
                       input int unsigned exp_id, input logic [7:0] exp_d, input logic exp_err,
                       input int unsigned bp, input bit hold);
    exp_t e;
    logic [3:0] g;
    g = 4'(1) << exp_id;
    req_valid = vm;
    req_op    = {4{op}};
    req_data  = {4{d}};
    rsp_ready = (bp == 0);
    #1;
    check("grant", 32'(req_ready), 32'(g));
    e.id = exp_id[1:0]; e.data = exp_d; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    check("exec_ready", 32'(req_ready), 32'(0));
    check("exec_busy", 32'(busy), 32'(1));
    check("exec_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    check("lat_valid", 32'(rsp_valid), 32'(1));
    for (int unsigned i = 0; i < bp; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'(1));
      check("bp_data", 32'(rsp_data), 32'(exp_d));
      check("bp_id", 32'(rsp_id), 32'(exp_id));
      check("bp_ready", 32'(req_ready), 32'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'(0));
    if (!hold) req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_op    = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #2;
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_data", 32'(rsp_data), 32'(0));
    check("rst_id", 32'(rsp_id), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single op: -1 from requester 0
    issue(4'b0001, 4'd2, 8'h01, 0, 8'hFF, 1'b0, 0, 0);
    // requester 3 pass-through, leaves ptr at 0
    issue(4'b1000, 4'd1, 8'h5A, 3, 8'h5A, 1'b0, 0, 0);
    // fairness with all valid held
    issue(4'b1111, 4'd8, 8'h07, 0, 8'h01, 1'b0, 0, 1);
    issue(4'b1111, 4'd8, 8'h07, 1, 8'h01, 1'b0, 0, 1);
    issue(4'b1111, 4'd8, 8'h07, 2, 8'h01, 1'b0, 0, 1);
    issue(4'b1111, 4'd8, 8'h07, 3, 8'h01, 1'b0, 0, 1);
    issue(4'b1111, 4'd8, 8'h07, 0, 8'h01, 1'b0, 0, 0);
    // backpressure, ptr now 1
    issue(4'b1111, 4'd0, 8'h3C, 1, 8'hC3, 1'b0, 5, 0);
    // reductions from requester 2
    issue(4'b0100, 4'd4, 8'hFF, 2, 8'h01, 1'b0, 0, 0);
    issue(4'b0100, 4'd5, 8'hFF, 2, 8'h00, 1'b0, 0, 0);
    issue(4'b0100, 4'd7, 8'hFF, 2, 8'h00, 1'b0, 0, 0);
    issue(4'b0100, 4'd9, 8'hFF, 2, 8'h01, 1'b0, 0, 0);
    issue(4'b0100, 4'd3, 8'h00, 2, 8'h01, 1'b0, 0, 0);
    issue(4'b1000, 4'd6, 8'h00, 3, 8'h00, 1'b0, 0, 0);
    // illegal op from requester 1
    issue(4'b0010, 4'hC, 8'h5A, 1, 8'h00, 1'b1, 0, 0);

    // reset while in RESP: response discarded, arbitration restarts at 0
    req_valid = 4'b0100;
    req_op    = {4{4'd0}};
    req_data  = '0;
    rsp_ready = 1'b0;
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(rsp_valid), 32'(1));
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    check("mid_rst_data", 32'(rsp_data), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'(4'b0001));
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_quiet", 32'(rsp_valid), 32'(0));
    end
    issue(4'b1111, 4'd1, 8'h5A, 0, 8'h5A, 1'b0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
